mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX2MEM pipeline register outputs, performs loads and stores over an SRAM-like data bus through a small request/response state machine, and presents the write-back triple to the MEM2WB register. It raises a stall request while a bus transaction is outstanding. It detects misaligned accesses without touching the bus.

---
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: loads/stores over an SRAM-like bus, write-back triple to MEM2WB.
// Latency: non-memory ops pass through combinationally; memory ops take IDLE+REQ+WAIT+DONE (min 3 stall cycles).
// Backpressure: stall_req_o holds MEM and earlier stages while a bus transaction is open; addr_ok/data_ok delays extend it.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   mem_wd_i/_wreg_i/_wdata_i     write-back triple from EX2MEM
//   mem_op_i, mem_addr_i          memory op code and effective address
//   mem_sdata_i                   store data (rt)
//   wb_wd_o/_wreg_o/_wdata_o      write-back triple to MEM2WB
//   stall_req_o, addr_err_o       pipeline hold request, misaligned-access flag
//   data_req_o .. data_wdata_o    bus request side
//   data_addr_ok_i, data_data_ok_i, data_rdata_i   bus handshake / read data
module mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic [4:0]  wb_wd_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wdata_o,
    output logic        stall_req_o,
    output logic        addr_err_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic        is_load, is_store, is_mem, sign_ext, misaligned, start_ok;
    logic [1:0]  size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] store_data;

    // ---------------- op decode ----------------
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SZ_BYTE;
        case (mem_op_i)
            OP_LB:  begin is_load  = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
            OP_LH:  begin is_load  = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
            OP_LW:  begin is_load  = 1'b1; size = SZ_WORD; end
            OP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
            OP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
            OP_SW:  begin is_store = 1'b1; size = SZ_WORD; end
            default: ;
        endcase
        is_mem     = is_load | is_store;
        misaligned = ((size == SZ_HALF) && mem_addr_i[0]) ||
                     ((size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00));
        start_ok   = is_mem & ~misaligned;
    end

    // ---------------- load extraction (little-endian) ----------------
    always_comb begin
        case (mem_addr_i[1:0])
            2'd0:    byte_sel = rbuf_q[7:0];
            2'd1:    byte_sel = rbuf_q[15:8];
            2'd2:    byte_sel = rbuf_q[23:16];
            default: byte_sel = rbuf_q[31:24];
        endcase
        half_sel = mem_addr_i[1] ? rbuf_q[31:16] : rbuf_q[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = rbuf_q;
        endcase
    end

    // Stores replicate the sub-word across all lanes so the slave can pick any lane.
    always_comb begin
        case (size)
            SZ_BYTE: store_data = {4{mem_sdata_i[7:0]}};
            SZ_HALF: store_data = {2{mem_sdata_i[15:0]}};
            default: store_data = mem_sdata_i;
        endcase
    end

    // ---------------- FSM next state / read buffer ----------------
    always_comb begin
        state_d = state_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = S_REQ;
            S_REQ:  if (data_addr_ok_i) state_d = S_WAIT;
            // data_ok is honoured only here, so a response left over from an
            // aborted transaction can never land in the buffer.
            S_WAIT: if (data_data_ok_i) begin
                        state_d = S_DONE;
                        if (is_load) rbuf_d = data_rdata_i;
                    end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rbuf_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        wb_wd_o     = mem_wd_i;
        wb_wreg_o   = mem_wreg_i;
        wb_wdata_o  = mem_wdata_i;
        addr_err_o  = is_mem & misaligned;
        data_req_o  = (state_q == S_REQ);
        stall_req_o = (state_q == S_REQ) || (state_q == S_WAIT) ||
                      ((state_q == S_IDLE) && start_ok);
        if (is_mem && misaligned) begin
            wb_wreg_o = 1'b0;
        end else if (is_load) begin
            // Load result only exists once the buffer is filled; keep the
            // register write suppressed until then.
            wb_wreg_o  = (state_q == S_DONE) ? mem_wreg_i : 1'b0;
            wb_wdata_o = (state_q == S_DONE) ? load_data : mem_wdata_i;
        end
        if (rst_i) begin
            wb_wd_o     = 5'd0;
            wb_wreg_o   = 1'b0;
            wb_wdata_o  = 32'd0;
            addr_err_o  = 1'b0;
            data_req_o  = 1'b0;
            stall_req_o = 1'b0;
        end
    end

    assign data_wr_o    = is_store;
    assign data_size_o  = size;
    assign data_addr_o  = mem_addr_i;
    assign data_wdata_o = store_data;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic        stall_req_o;
    logic        addr_err_o;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_stage dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .mem_wd_i       (mem_wd_i),
        .mem_wreg_i     (mem_wreg_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_op_i       (mem_op_i),
        .mem_addr_i     (mem_addr_i),
        .mem_sdata_i    (mem_sdata_i),
        .wb_wd_o        (wb_wd_o),
        .wb_wreg_o      (wb_wreg_o),
        .wb_wdata_o     (wb_wdata_o),
        .stall_req_o    (stall_req_o),
        .addr_err_o     (addr_err_o),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          adly;
        int          ddly;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] e_wdata;
        bit          chk_wdata;
        logic        e_wreg;
        int          e_stall;
        int          e_req;
        logic        e_err;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_bwdata;
    } vec_t;

    // Captured results of the last transaction
    logic [4:0]  r_wd;
    logic        r_wreg;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_bwdata;
    logic [31:0] r_addr;
    logic        r_timeout;
    int          r_stall;
    int          r_req;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, sdata, rdata,
                                input int adly, ddly, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, e_wdata, input bit chk_wdata,
                                input logic e_wreg, input int e_stall, e_req, input logic e_err,
                                input logic e_wr, input logic [1:0] e_size, input logic [31:0] e_bwdata);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.adly = adly; v.ddly = ddly; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
        v.e_wdata = e_wdata; v.chk_wdata = chk_wdata; v.e_wreg = e_wreg;
        v.e_stall = e_stall; v.e_req = e_req; v.e_err = e_err;
        v.e_wr = e_wr; v.e_size = e_size; v.e_bwdata = e_bwdata;
        return v;
    endfunction

    // Reference model: access width in bytes, alignment by modulo, lane
    // extraction by shift/mask and sign extension by subtracting 2^bits.
    function automatic vec_t model(input vec_t vin);
        vec_t   v;
        int     w;
        bit     st;
        bit     sgn;
        longint mask;
        longint raw;
        longint rep;
        v   = vin;
        st  = (v.op >= 4'd6) && (v.op <= 4'd8);
        sgn = (v.op == 4'd1) || (v.op == 4'd3) || (v.op == 4'd5);
        case (v.op)
            4'd1, 4'd2, 4'd6: w = 1;
            4'd3, 4'd4, 4'd7: w = 2;
            4'd5, 4'd8:       w = 4;
            default:          w = 0;
        endcase
        v.e_wdata = v.wdata; v.chk_wdata = 1'b1; v.e_wreg = v.wreg;
        v.e_stall = 0; v.e_req = 0; v.e_err = 1'b0;
        v.e_wr = 1'b0; v.e_size = 2'd0; v.e_bwdata = 32'd0;
        if (w != 0) begin
            if ((int'(v.addr[1:0]) % w) != 0) begin
                v.e_err = 1'b1; v.e_wreg = 1'b0; v.chk_wdata = 1'b0;
            end else begin
                v.e_stall = 3 + v.adly + v.ddly;
                v.e_req   = v.adly + 1;
                v.e_wr    = st;
                v.e_size  = (w == 1) ? 2'd0 : (w == 2) ? 2'd1 : 2'd2;
                mask      = (64'sd1 <<< (8 * w)) - 1;
                if (st) begin
                    v.chk_wdata = 1'b0;
                    rep = (w == 1) ? 64'h01010101 : (w == 2) ? 64'h00010001 : 64'd1;
                    v.e_bwdata = 32'((longint'(v.sdata) & mask) * rep);
                end else begin
                    raw = (longint'(v.rdata) >> (8 * int'(v.addr[1:0]))) & mask;
                    if (sgn && raw >= (mask + 1) / 2) raw = raw - (mask + 1);
                    v.e_wdata = 32'(raw);
                end
            end
        end
        return v;
    endfunction

    // Drive one op, acting as the bus slave with the vector's delays, and
    // capture the outputs in the first cycle that does not stall.
    task automatic txn(input vec_t v);
        int wcnt;
        bit accepted;
        @(negedge clk_i);
        mem_op_i = v.op; mem_addr_i = v.addr; mem_sdata_i = v.sdata;
        mem_wd_i = v.wd; mem_wreg_i = v.wreg; mem_wdata_i = v.wdata;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'hDEADBEEF;
        r_stall = 0; r_req = 0; r_timeout = 1'b1; accepted = 1'b0; wcnt = 0;
        r_wr = 1'b0; r_size = 2'd0; r_bwdata = 32'd0; r_addr = 32'd0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (!stall_req_o) begin
                r_wd = wb_wd_o; r_wreg = wb_wreg_o; r_wdata = wb_wdata_o; r_err = addr_err_o;
                if (data_req_o) r_req++;
                r_timeout = 1'b0;
                break;
            end
            r_stall++;
            data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'hDEADBEEF;
            if (data_req_o) begin
                r_req++;
                r_wr = data_wr_o; r_size = data_size_o; r_bwdata = data_wdata_o; r_addr = data_addr_o;
                data_addr_ok_i = (r_req > v.adly);
                accepted = data_addr_ok_i;
            end else if (accepted) begin
                wcnt++;
                if (wcnt > v.ddly) begin
                    data_data_ok_i = 1'b1;
                    data_rdata_i   = v.rdata;
                end
            end
            @(negedge clk_i);
        end
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
        if (r_stall == 0) begin
            // Hold a non-stalling op a little longer: no request may appear.
            for (int k = 0; k < 2; k++) begin
                @(negedge clk_i); #1;
                if (data_req_o || stall_req_o) r_req++;
            end
        end
        mem_op_i = 4'd0;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        txn(v);
        chk({tag, ".done"},  32'(r_timeout), 32'd0);
        chk({tag, ".wd"},    32'(r_wd),      32'(v.wd));
        chk({tag, ".wreg"},  32'(r_wreg),    32'(v.e_wreg));
        if (v.chk_wdata) chk({tag, ".wdata"}, r_wdata, v.e_wdata);
        chk({tag, ".stall"}, 32'(r_stall),   32'(v.e_stall));
        chk({tag, ".req"},   32'(r_req),     32'(v.e_req));
        chk({tag, ".err"},   32'(r_err),     32'(v.e_err));
        if (v.e_req > 0) begin
            chk({tag, ".wr"},   32'(r_wr),   32'(v.e_wr));
            chk({tag, ".size"}, 32'(r_size), 32'(v.e_size));
            chk({tag, ".baddr"}, r_addr, v.addr);
            if (v.e_wr) chk({tag, ".bwdata"}, r_bwdata, v.e_bwdata);
        end
    endtask

    vec_t tbl[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //        op    addr          sdata         rdata         ad dd wd wr wdata         e_wdata       cw ew st rq er wr sz bwdata
        tbl[0]  = mk(4'd0, 32'h0,        32'h0,        32'h0,        0, 0, 5, 1, 32'h1234,     32'h1234,     1, 1, 0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = mk(4'd1, 32'h80000003, 32'h0,        32'h80FF1122, 0, 0, 3, 1, 32'h0,        32'hFFFFFF80, 1, 1, 3, 1, 0, 0, 0, 32'h0);
        tbl[2]  = mk(4'd2, 32'h80000003, 32'h0,        32'h80FF1122, 0, 0, 3, 1, 32'h0,        32'h00000080, 1, 1, 3, 1, 0, 0, 0, 32'h0);
        tbl[3]  = mk(4'd3, 32'h00000102, 32'h0,        32'h8001ABCD, 2, 0, 4, 1, 32'h0,        32'hFFFF8001, 1, 1, 5, 3, 0, 0, 1, 32'h0);
        tbl[4]  = mk(4'd4, 32'h00000010, 32'h0,        32'h8001ABCD, 0, 1, 6, 1, 32'h0,        32'h0000ABCD, 1, 1, 4, 1, 0, 0, 1, 32'h0);
        tbl[5]  = mk(4'd5, 32'h00000100, 32'h0,        32'hCAFEF00D, 1, 2, 7, 1, 32'h0,        32'hCAFEF00D, 1, 1, 6, 2, 0, 0, 2, 32'h0);
        tbl[6]  = mk(4'd1, 32'h00000021, 32'h0,        32'h80FF1122, 0, 0, 8, 1, 32'h0,        32'h00000011, 1, 1, 3, 1, 0, 0, 0, 32'h0);
        tbl[7]  = mk(4'd2, 32'h00000022, 32'h0,        32'h80FF1122, 0, 0, 8, 1, 32'h0,        32'h000000FF, 1, 1, 3, 1, 0, 0, 0, 32'h0);
        tbl[8]  = mk(4'd6, 32'h00001001, 32'h000000A5, 32'h0,        0, 0, 0, 0, 32'h1001,     32'h0,        0, 0, 3, 1, 0, 1, 0, 32'hA5A5A5A5);
        tbl[9]  = mk(4'd7, 32'h00001002, 32'h1234BEEF, 32'h0,        1, 0, 9, 1, 32'h1002,     32'h0,        0, 1, 4, 2, 0, 1, 1, 32'hBEEFBEEF);
        tbl[10] = mk(4'd8, 32'h00001004, 32'h01234567, 32'h0,        0, 2, 0, 0, 32'h1004,     32'h0,        0, 0, 5, 1, 0, 1, 2, 32'h01234567);
        tbl[11] = mk(4'd5, 32'h00001002, 32'h0,        32'h0,        0, 0, 2, 1, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0, 0, 32'h0);
        tbl[12] = mk(4'd7, 32'h00001001, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0, 0, 32'h0);
        tbl[13] = mk(4'd4, 32'h00001003, 32'h0,        32'h0,        0, 0, 2, 1, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0, 0, 32'h0);
        tbl[14] = mk(4'd9, 32'h00001003, 32'h0,        32'h0,        0, 0,31, 1, 32'hA5A50F0F, 32'hA5A50F0F, 1, 1, 0, 0, 0, 0, 0, 32'h0);
        tbl[15] = mk(4'd8, 32'h00001001, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0, 0, 32'h0);

        // ---------- reset: outputs forced idle even with live inputs ----------
        rst_i = 1'b1;
        mem_op_i = 4'd5; mem_addr_i = 32'h0; mem_sdata_i = 32'h0;
        mem_wd_i = 5'd7; mem_wreg_i = 1'b1; mem_wdata_i = 32'hFFFF;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
        @(negedge clk_i); @(negedge clk_i); #1;
        chk("rst.stall", 32'(stall_req_o), 32'd0);
        chk("rst.req",   32'(data_req_o),  32'd0);
        chk("rst.wreg",  32'(wb_wreg_o),   32'd0);
        chk("rst.wd",    32'(wb_wd_o),     32'd0);
        chk("rst.wdata", wb_wdata_o,       32'd0);
        mem_addr_i = 32'h2;
        #1;
        chk("rst.err",   32'(addr_err_o),  32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; mem_op_i = 4'd0; mem_addr_i = 32'h0;
        mem_wd_i = 5'd0; mem_wreg_i = 1'b0; mem_wdata_i = 32'h0;
        @(negedge clk_i); #1;
        chk("post_rst.stall", 32'(stall_req_o), 32'd0);
        chk("post_rst.req",   32'(data_req_o),  32'd0);
        chk("post_rst.wreg",  32'(wb_wreg_o),   32'd0);
        chk("post_rst.err",   32'(addr_err_o),  32'd0);
        chk("post_rst.rbuf",  dut.rbuf_q,       32'd0);

        // ---------- reset in WAIT, stale data_ok afterwards ----------
        @(negedge clk_i);
        mem_op_i = 4'd5; mem_addr_i = 32'h40; mem_wd_i = 5'd9; mem_wreg_i = 1'b1;
        #1;
        chk("abort.idle_stall", 32'(stall_req_o), 32'd1);
        @(negedge clk_i); #1;
        chk("abort.req", 32'(data_req_o), 32'd1);
        data_addr_ok_i = 1'b1;
        @(negedge clk_i); #1;
        chk("abort.wait_req",   32'(data_req_o),  32'd0);
        chk("abort.wait_stall", 32'(stall_req_o), 32'd1);
        data_addr_ok_i = 1'b0; rst_i = 1'b1;
        mem_op_i = 4'd0; mem_wd_i = 5'd0; mem_wreg_i = 1'b0;
        @(negedge clk_i); #1;
        chk("abort.rst_stall", 32'(stall_req_o), 32'd0);
        rst_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h12345678;
        @(negedge clk_i); #1;
        chk("abort.stale_stall", 32'(stall_req_o), 32'd0);
        chk("abort.stale_req",   32'(data_req_o),  32'd0);
        chk("abort.rbuf",        dut.rbuf_q,       32'd0);
        data_data_ok_i = 1'b0; data_rdata_i = 32'hDEADBEEF;

        // ---------- directed table ----------
        for (int i = 0; i < 16; i++) check_vec(tbl[i], $sformatf("vec%0d", i));

        // ---------- randomized against the reference model ----------
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v.op    = 4'($urandom_range(0, 15));
            v.addr  = $urandom;
            if ($urandom_range(0, 1) == 0) v.addr[1:0] = 2'b00;
            v.sdata = $urandom;
            v.rdata = $urandom;
            v.adly  = $urandom_range(0, 3);
            v.ddly  = $urandom_range(0, 3);
            v.wd    = 5'($urandom);
            v.wreg  = 1'($urandom);
            v.wdata = $urandom;
            v = model(v);
            check_vec(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
